shadow_vector: RTL and testbench

- Iterative CORDIC (vectoring mode) engine for the sundial shadow pipeline.
- Takes the gnomon base point (x0,y0), the shadow-tip centroid (x,y) and the blob mass. Returns shadow length (Euclidean magnitude) and shadow bearing (binary angle).
- Sits after the centroid/mass stage and feeds time-of-day lookup.
- Successor to the single-result length block: parametrised widths and iteration count, ready/valid handshake, full 360-degree angle output, and a mass-gated no-shadow flag.

---
 rtl/shadow_vector.sv | 217 +++++++++++++++++++++
 tb/tb_shadow_vector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shadow_vector.sv
// Iterative vectoring-mode CORDIC: shadow length and 16-bit bearing from base point to tip.
// Optional macro SUNDIAL_LENGTH_IIR_EN enables first-order smoothing of length_out.
module shadow_vector #(
   parameter int unsigned XW        = 11,
   parameter int unsigned YW        = 10,
   parameter int unsigned ITER      = 14,
   parameter logic [31:0] MIN_MASS  = 32'd64,
   parameter int unsigned IIR_SHIFT = 2
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          data_valid_in,
   input  logic [XW-1:0] x0_in,
   input  logic [YW-1:0] y0_in,
   input  logic [XW-1:0] x_in,
   input  logic [YW-1:0] y_in,
   input  logic [31:0]   mass_in,
   output logic          ready_out,
   output logic [XW:0]   length_out,
   output logic [15:0]   angle_out,
   output logic          no_shadow_out,
   output logic          valid_out
);

   // Integer part is XW+3 bits; guard fraction bits keep the floor bias of the
   // arithmetic shifts from accumulating into the magnitude and bearing.
   localparam int unsigned GB = 8;
   localparam int unsigned DW = XW + 3 + GB;
   localparam int unsigned PW = DW + 17;
   localparam logic [PW-1:0] GAIN_INV = PW'(39797);
   localparam logic [PW-1:0] ROUND    = PW'(1) << (15 + GB);
   localparam logic [15:0] ATAN [16] = '{
      16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
      16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
   };

   typedef enum logic [1:0] {StIdle, StPrep, StRot, StScale} state_t;

   state_t               state_q, state_d;
   logic [XW-1:0]        x0_q, x0_d, xt_q, xt_d;
   logic [YW-1:0]        y0_q, y0_d, yt_q, yt_d;
   logic                 low_mass_q, low_mass_d;
   logic signed [DW-1:0] xr_q, xr_d, yr_q, yr_d;
   logic [15:0]          z_q, z_d;
   logic [3:0]           iter_q, iter_d;
   logic [XW:0]          length_q, length_d;
   logic [15:0]          angle_q, angle_d;
   logic                 no_shadow_q, no_shadow_d;
   logic                 valid_q, valid_d;

   logic signed [XW:0]   dx, dy;
   logic signed [DW-1:0] dx_ext, dy_ext, x_sh, y_sh;
   logic [DW-1:0]        x_mag;
   logic [PW-1:0]        prod;
   logic [XW:0]          raw_len;

   assign dx     = $signed({1'b0, xt_q}) - $signed({1'b0, x0_q});
   assign dy     = $signed((XW+1)'(yt_q)) - $signed((XW+1)'(y0_q));
   assign dx_ext = {{2{dx[XW]}}, dx, {GB{1'b0}}};
   assign dy_ext = {{2{dy[XW]}}, dy, {GB{1'b0}}};
   assign x_sh   = xr_q >>> iter_q;
   assign y_sh   = yr_q >>> iter_q;
   assign x_mag  = xr_q[DW-1] ? '0 : xr_q;
   assign prod   = PW'(x_mag) * GAIN_INV + ROUND;
   assign raw_len = (XW+1)'(prod >> (16 + GB));

`ifdef SUNDIAL_LENGTH_IIR_EN
   localparam int unsigned AW = XW + 1 + IIR_SHIFT;
   logic [AW-1:0]   acc_q, acc_d, acc_raw, acc_step;
   logic            acc_vld_q, acc_vld_d;
   logic signed [AW:0] acc_diff;

   assign acc_raw  = {raw_len, {IIR_SHIFT{1'b0}}};
   assign acc_diff = $signed({1'b0, acc_raw}) - $signed({1'b0, acc_q});
   assign acc_step = acc_q + AW'(acc_diff >>> IIR_SHIFT);
`else
   // Smoothing shift has no effect in the raw-length build.
   if (IIR_SHIFT > 0) begin : g_iir_unused
   end
`endif

   always_comb begin
      state_d     = state_q;
      x0_d        = x0_q;
      y0_d        = y0_q;
      xt_d        = xt_q;
      yt_d        = yt_q;
      low_mass_d  = low_mass_q;
      xr_d        = xr_q;
      yr_d        = yr_q;
      z_d         = z_q;
      iter_d      = iter_q;
      length_d    = length_q;
      angle_d     = angle_q;
      no_shadow_d = no_shadow_q;
      valid_d     = 1'b0;
`ifdef SUNDIAL_LENGTH_IIR_EN
      acc_d       = acc_q;
      acc_vld_d   = acc_vld_q;
`endif
      case (state_q)
         StIdle: begin
            if (data_valid_in) begin
               x0_d       = x0_in;
               y0_d       = y0_in;
               xt_d       = x_in;
               yt_d       = y_in;
               low_mass_d = (mass_in < MIN_MASS);
               state_d    = StPrep;
            end
         end
         StPrep: begin
            // Fold the left half-plane onto the right so CORDIC converges.
            if (dx < 0) begin
               xr_d = -dx_ext;
               yr_d = -dy_ext;
               z_d  = 16'd32768;
            end else begin
               xr_d = dx_ext;
               yr_d = dy_ext;
               z_d  = 16'd0;
            end
            iter_d  = 4'd0;
            state_d = StRot;
         end
         StRot: begin
            if (!yr_q[DW-1]) begin
               xr_d = xr_q + y_sh;
               yr_d = yr_q - x_sh;
               z_d  = z_q + ATAN[iter_q];
            end else begin
               xr_d = xr_q - y_sh;
               yr_d = yr_q + x_sh;
               z_d  = z_q - ATAN[iter_q];
            end
            iter_d = iter_q + 4'd1;
            if (iter_q == 4'(ITER - 1)) begin
               state_d = StScale;
            end
         end
         StScale: begin
            valid_d = 1'b1;
            state_d = StIdle;
            if (low_mass_q) begin
               length_d    = '0;
               angle_d     = '0;
               no_shadow_d = 1'b1;
            end else begin
`ifdef SUNDIAL_LENGTH_IIR_EN
               if (acc_vld_q) begin
                  acc_d    = acc_step;
                  length_d = acc_step[AW-1:IIR_SHIFT];
               end else begin
                  acc_d     = acc_raw;
                  acc_vld_d = 1'b1;
                  length_d  = raw_len;
               end
`else
               length_d    = raw_len;
`endif
               angle_d     = z_q;
               no_shadow_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         x0_q        <= '0;
         y0_q        <= '0;
         xt_q        <= '0;
         yt_q        <= '0;
         low_mass_q  <= 1'b0;
         xr_q        <= '0;
         yr_q        <= '0;
         z_q         <= '0;
         iter_q      <= '0;
         length_q    <= '0;
         angle_q     <= '0;
         no_shadow_q <= 1'b0;
         valid_q     <= 1'b0;
`ifdef SUNDIAL_LENGTH_IIR_EN
         acc_q       <= '0;
         acc_vld_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         xt_q        <= xt_d;
         yt_q        <= yt_d;
         low_mass_q  <= low_mass_d;
         xr_q        <= xr_d;
         yr_q        <= yr_d;
         z_q         <= z_d;
         iter_q      <= iter_d;
         length_q    <= length_d;
         angle_q     <= angle_d;
         no_shadow_q <= no_shadow_d;
         valid_q     <= valid_d;
`ifdef SUNDIAL_LENGTH_IIR_EN
         acc_q       <= acc_d;
         acc_vld_q   <= acc_vld_d;
`endif
      end
   end

   assign ready_out     = (state_q == StIdle);
   assign length_out    = length_q;
   assign angle_out     = angle_q;
   assign no_shadow_out = no_shadow_q;
   assign valid_out     = valid_q;

endmodule

// File: tb/tb_shadow_vector.sv
// Directed bench for shadow_vector: latency, CORDIC results, mass gating, handshake, reset abort.
module tb_shadow_vector;

   localparam int ITER = 14;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dv = 1'b0;
   logic [10:0] x0 = '0, xt = '0;
   logic [9:0]  y0 = '0, yt = '0;
   logic [31:0] mass = '0;
   logic        ready, valid, ns;
   logic [11:0] length;
   logic [15:0] angle;

   int checks = 0;
   int failures = 0;
   int lat;

   always #5 clk = ~clk;

   shadow_vector dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .data_valid_in (dv),
      .x0_in         (x0),
      .y0_in         (y0),
      .x_in          (xt),
      .y_in          (yt),
      .mass_in       (mass),
      .ready_out     (ready),
      .length_out    (length),
      .angle_out     (angle),
      .no_shadow_out (ns),
      .valid_out     (valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [31:0] obs,
                          input logic [31:0] lo, input logic [31:0] hi);
      checks++;
      assert ((obs >= lo) && (obs <= hi)) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      dv  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Launch one sample and wait (bounded) for its result strobe.
   task automatic send(input logic [10:0] ax0, input logic [9:0] ay0,
                       input logic [10:0] ax, input logic [9:0] ay, input logic [31:0] am);
      int n;
      n = 0;
      @(negedge clk);
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      x0 = ax0; y0 = ay0; xt = ax; yt = ay; mass = am;
      dv = 1'b1;
      @(posedge clk);
      #1;
      dv = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            lat = k;
            break;
         end
      end
      chk("latency", lat, ITER + 2);
   endtask

   initial begin
      int accepts, vcnt, bad, stray;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_valid", valid, 0);
      chk("rst_length", length, 0);
      chk("rst_angle", angle, 0);
      chk("rst_noshadow", ns, 0);

      reset_dut();
      send(0, 0, 10, 10, 2000);
      chk("diag_length", length, 14);
      chk_rng("diag_angle", angle, 8184, 8200);
      chk("diag_noshadow", ns, 0);
      @(posedge clk);
      #1;
      chk("strobe_one_cycle", valid, 0);
      chk("length_hold", length, 14);

      reset_dut();
      send(10, 10, 100, 20, 3000);
      chk_rng("shallow_length", length, 90, 91);
      chk_rng("shallow_angle", angle, 1146, 1162);

      reset_dut();
      send(0, 100, 0, 90, 2000);
      chk("down_length", length, 10);
      chk_rng("down_angle", angle, 49144, 49160);

      reset_dut();
      send(100, 100, 50, 100, 2000);
      chk("left_length", length, 50);
      chk_rng("left_angle", angle, 32760, 32776);

      reset_dut();
      send(0, 0, 10, 10, 63);
      chk("mass63_noshadow", ns, 1);
      chk("mass63_length", length, 0);
      chk("mass63_angle", angle, 0);
      send(0, 0, 10, 10, 64);
      chk("mass64_noshadow", ns, 0);
      chk("mass64_length", length, 14);

      // Continuous data_valid_in: accepts at edges 0, 17 and 34 of a 40-cycle window.
      accepts = 0; vcnt = 0; bad = 0;
      @(negedge clk);
      x0 = 0; y0 = 0; xt = 10; yt = 10; mass = 2000;
      dv = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (ready) accepts++;
         @(posedge clk);
         #1;
         if (valid) begin
            vcnt++;
            if (!ready) bad++;
         end
         @(negedge clk);
      end
      dv = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            vcnt++;
            if (!ready) bad++;
         end
      end
      chk("stream_accepts", accepts, 3);
      chk("stream_valids", vcnt, 3);
      chk("stream_ready_with_valid", bad, 0);

      // Reset while rotating aborts without a strobe.
      @(negedge clk);
      x0 = 0; y0 = 0; xt = 10; yt = 10; mass = 2000;
      dv = 1'b1;
      @(posedge clk);
      #1;
      dv = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_valid", valid, 0);
      chk("abort_length", length, 0);
      chk("abort_angle", angle, 0);
      chk("abort_ready", ready, 1);
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (valid) stray++;
      end
      chk("abort_no_strobe", stray, 0);

      send(0, 0, 10, 10, 2000);
      chk("after_abort_length", length, 14);
      send(100, 100, 50, 100, 2000);
`ifdef SUNDIAL_LENGTH_IIR_EN
      chk("second_length", length, 23);
`else
      chk("second_length", length, 50);
`endif
      chk_rng("second_angle", angle, 32760, 32776);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
